rv32_pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller that generates the stall, flush and busy controls for the IF/ID and ID/EX pipeline registers and the PC. It detects load-use hazards, runs a multi-cycle flush after taken branches/jumps, and freezes the pipeline while a multi-cycle execute unit (MDU) or a data-memory access is outstanding. Sits beside the decode stage and drives the flush/stall/busy inputs of the ID/EX queue directly.

---
 rtl/rv32_pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/rv32_pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_rv32_pipe_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the decode/execute pipeline and the sequencing controller.
// The controller takes the slave modport. The pipeline (or a bench) takes the master modport.
interface rv32_pipe_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       branch_taken;
  logic       mdu_start;
  logic       mdu_done;
  logic       dmem_req;
  logic       dmem_ack;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_stall;
  logic       id_ex_flush;
  logic       pipe_busy;
  logic       mdu_timeout;
  logic [2:0] state;

  // Handshake: dmem_req is held by MEM until the cycle dmem_ack is seen; an ack
  // in the request cycle completes the access with no stall. mdu_start and
  // mdu_done are single-cycle pulses, and mdu_done is accepted only in MDU_WAIT.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           branch_taken, mdu_start, mdu_done, dmem_req, dmem_ack,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           pipe_busy, mdu_timeout, state
  );

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           branch_taken, mdu_start, mdu_done, dmem_req, dmem_ack,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           pipe_busy, mdu_timeout, state
  );
endinterface

// File: rtl/rv32_pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flush window, and freezes
// while an MDU op or a data-memory access is outstanding.
module rv32_pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MDU_TIMEOUT  = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  rv32_pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    FLUSH    = 3'd1,
    MDU_WAIT = 3'd2,
    MEM_WAIT = 3'd3
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TO_LAST      = 8'(MDU_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       pending_q, pending_d;
  logic       armed_q;
  logic       load_use;

  // Outputs stay quiet for the first full cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      to_cnt_q    <= '0;
      pending_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pending_q   <= pending_d;
      armed_q     <= 1'b1;
    end
  end

  assign load_use = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    to_cnt_d       = to_cnt_q;
    pending_d      = pending_q;
    hz.pc_stall    = 1'b0;
    hz.if_id_stall = 1'b0;
    hz.if_id_flush = 1'b0;
    hz.id_ex_stall = 1'b0;
    hz.id_ex_flush = 1'b0;
    hz.pipe_busy   = 1'b0;
    hz.mdu_timeout = 1'b0;

    if (armed_q) begin
      unique case (state_q)
        RUN: begin
          if (hz.branch_taken) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = FLUSH;
              flush_cnt_d = FLUSH_RELOAD;
            end
          end else if (hz.dmem_req && !hz.dmem_ack) begin
            hz.pipe_busy   = 1'b1;
            hz.pc_stall    = 1'b1;
            hz.if_id_stall = 1'b1;
            state_d        = MEM_WAIT;
            if (hz.mdu_start) pending_d = 1'b1;
          end else if (hz.mdu_start) begin
            hz.pipe_busy   = 1'b1;
            hz.pc_stall    = 1'b1;
            hz.if_id_stall = 1'b1;
            state_d        = MDU_WAIT;
            to_cnt_d       = '0;
          end else if (load_use) begin
            hz.pc_stall    = 1'b1;
            hz.if_id_stall = 1'b1;
            hz.id_ex_stall = 1'b1;
          end
        end

        FLUSH: begin
          hz.if_id_flush = 1'b1;
          hz.id_ex_flush = 1'b1;
          if (hz.branch_taken) begin
            flush_cnt_d = FLUSH_RELOAD;
          end else if (flush_cnt_q <= 3'd1) begin
            state_d     = RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end

        MEM_WAIT: begin
          if (!hz.dmem_ack) begin
            hz.pipe_busy   = 1'b1;
            hz.pc_stall    = 1'b1;
            hz.if_id_stall = 1'b1;
          end else if (pending_q) begin
            state_d   = MDU_WAIT;
            pending_d = 1'b0;
            to_cnt_d  = '0;
          end else begin
            state_d = RUN;
          end
        end

        MDU_WAIT: begin
          // A done arriving on the last allowed cycle beats the abort.
          if (hz.mdu_done) begin
            state_d = RUN;
          end else if (to_cnt_q >= TO_LAST) begin
            hz.mdu_timeout = 1'b1;
            state_d        = RUN;
          end else begin
            hz.pipe_busy   = 1'b1;
            hz.pc_stall    = 1'b1;
            hz.if_id_stall = 1'b1;
            to_cnt_d       = to_cnt_q + 8'd1;
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

  assign hz.state = state_q;

endmodule

// File: tb/tb_rv32_pipe_hazard_ctrl.sv
// Directed bench for rv32_pipe_hazard_ctrl with default parameters (FLUSH_CYCLES=2, MDU_TIMEOUT=64).
module tb_rv32_pipe_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  rv32_pipe_hazard_ctrl_if hz ();

  rv32_pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MDU_TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: [9:7] state, then pc_stall, if_id_stall, if_id_flush,
  // id_ex_stall, id_ex_flush, pipe_busy, mdu_timeout.
  localparam logic [2:0] S_RUN = 3'd0, S_FL = 3'd1, S_MDU = 3'd2, S_MEM = 3'd3;
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1101000;
  localparam logic [6:0] O_FL   = 7'b0010100;
  localparam logic [6:0] O_BUSY = 7'b1100010;
  localparam logic [6:0] O_TO   = 7'b0000001;

  function automatic logic [9:0] obs();
    return {hz.state, hz.pc_stall, hz.if_id_stall, hz.if_id_flush,
            hz.id_ex_stall, hz.id_ex_flush, hz.pipe_busy, hz.mdu_timeout};
  endfunction

  // driver tasks
  task automatic idle();
    hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
    hz.ex_rd = 5'd0; hz.ex_is_load = 1'b0; hz.branch_taken = 1'b0;
    hz.mdu_start = 1'b0; hz.mdu_done = 1'b0; hz.dmem_req = 1'b0; hz.dmem_ack = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic ld);
    hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.id_uses_rs1 = u1; hz.id_uses_rs2 = u2;
    hz.ex_rd = rd; hz.ex_is_load = ld;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    idle();
    rst_n = 1'b0;
    hz.branch_taken = 1'b1;
    hz.mdu_start = 1'b1;
    #17;
    got = obs(); n_cmp++;
    if (got !== {S_RUN, O_NONE}) begin
      n_fail++; $display("FAIL reset_held: got %b want %b", got, {S_RUN, O_NONE});
    end
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_lu(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1);
    @(negedge clk);
    got = obs(); n_cmp++;
    if (got !== {S_RUN, O_NONE}) begin
      n_fail++; $display("FAIL reset_first_cycle: got %b want %b", got, {S_RUN, O_NONE});
    end
    next_cycle();
    idle();
  endtask

  task automatic test_load_use();
    logic [9:0] got;
    logic [9:0] exp_v [0:5];
    exp_v = '{{S_RUN, O_LU}, {S_RUN, O_NONE}, {S_RUN, O_NONE},
              {S_RUN, O_LU}, {S_RUN, O_NONE}, {S_RUN, O_NONE}};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: set_lu(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1);   // rs2 hit
        1: set_lu(5'd1, 5'd5, 1'b1, 1'b1, 5'd9, 1'b0);   // bubble in EX now
        2: set_lu(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1);   // x0 never hazards
        3: set_lu(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1);   // rs1 hit
        4: set_lu(5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1);   // operand unused
        default: set_lu(5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b0); // not a load
      endcase
      @(negedge clk);
      got = obs(); n_cmp++;
      if (got !== exp_v[i]) begin
        n_fail++; $display("FAIL load_use[%0d]: got %b want %b", i, got, exp_v[i]);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_branch_flush();
    logic [9:0] got;
    logic [9:0] exp_v [0:9];
    exp_v = '{{S_RUN, O_FL}, {S_FL, O_FL}, {S_RUN, O_NONE},
              {S_RUN, O_FL}, {S_FL, O_FL}, {S_RUN, O_NONE},
              {S_RUN, O_FL}, {S_FL, O_FL}, {S_FL, O_FL}, {S_RUN, O_NONE}};
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i == 0 || i == 6 || i == 7) hz.branch_taken = 1'b1;
      if (i == 3) hz.branch_taken = 1'b1;
      if (i == 3 || i == 4) set_lu(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1);
      @(negedge clk);
      got = obs(); n_cmp++;
      if (got !== exp_v[i]) begin
        n_fail++; $display("FAIL branch_flush[%0d]: got %b want %b", i, got, exp_v[i]);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_mdu_done();
    logic [9:0] got;
    logic [9:0] exp_v;
    for (int i = 0; i < 9; i++) begin
      idle();
      if (i == 0) hz.mdu_start = 1'b1;
      if (i == 3) begin hz.branch_taken = 1'b1; hz.mdu_start = 1'b1; end
      if (i == 7) hz.mdu_done = 1'b1;
      if (i == 0)      exp_v = {S_RUN, O_BUSY};
      else if (i < 7)  exp_v = {S_MDU, O_BUSY};
      else if (i == 7) exp_v = {S_MDU, O_NONE};
      else             exp_v = {S_RUN, O_NONE};
      @(negedge clk);
      got = obs(); n_cmp++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL mdu_done[%0d]: got %b want %b", i, got, exp_v);
      end
      next_cycle();
    end
    idle();
  endtask

  // cycle 0 is the mdu_start cycle in RUN; MDU_WAIT cycle k is loop index k+1
  task automatic test_mdu_timeout(input logic done_on_last);
    logic [9:0] got;
    logic [9:0] exp_v;
    for (int i = 0; i < 66; i++) begin
      idle();
      if (i == 0) hz.mdu_start = 1'b1;
      if (i == 64 && done_on_last) hz.mdu_done = 1'b1;
      if (i == 0)       exp_v = {S_RUN, O_BUSY};
      else if (i < 64)  exp_v = {S_MDU, O_BUSY};
      else if (i == 64) exp_v = done_on_last ? {S_MDU, O_NONE} : {S_MDU, O_TO};
      else              exp_v = {S_RUN, O_NONE};
      @(negedge clk);
      got = obs();
      if (i == 0 || i == 1 || i >= 62) begin
        n_cmp++;
        if (got !== exp_v) begin
          n_fail++; $display("FAIL mdu_timeout(done=%0b)[%0d]: got %b want %b",
                             done_on_last, i, got, exp_v);
        end
      end else if (got !== exp_v) begin
        n_cmp++; n_fail++;
        $display("FAIL mdu_timeout_busy[%0d]: got %b want %b", i, got, exp_v);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_mem_then_mdu();
    logic [9:0] got;
    logic [9:0] exp_v [0:8];
    exp_v = '{{S_RUN, O_BUSY}, {S_MEM, O_BUSY}, {S_MEM, O_BUSY}, {S_MEM, O_NONE},
              {S_MDU, O_BUSY}, {S_MDU, O_BUSY}, {S_MDU, O_BUSY}, {S_MDU, O_NONE},
              {S_RUN, O_NONE}};
    for (int i = 0; i < 9; i++) begin
      idle();
      if (i <= 3) hz.dmem_req = 1'b1;
      if (i == 0) hz.mdu_start = 1'b1;
      if (i == 2) hz.branch_taken = 1'b1;
      if (i == 3) hz.dmem_ack = 1'b1;
      if (i == 7) hz.mdu_done = 1'b1;
      @(negedge clk);
      got = obs(); n_cmp++;
      if (got !== exp_v[i]) begin
        n_fail++; $display("FAIL mem_then_mdu[%0d]: got %b want %b", i, got, exp_v[i]);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_back_to_back_mem();
    logic [9:0] got;
    logic [9:0] exp_v [0:4];
    exp_v = '{{S_RUN, O_NONE}, {S_RUN, O_BUSY}, {S_MEM, O_NONE},
              {S_RUN, O_NONE}, {S_RUN, O_NONE}};
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i <= 2) hz.dmem_req = 1'b1;
      if (i == 0 || i == 2) hz.dmem_ack = 1'b1;
      @(negedge clk);
      got = obs(); n_cmp++;
      if (got !== exp_v[i]) begin
        n_fail++; $display("FAIL back_to_back_mem[%0d]: got %b want %b", i, got, exp_v[i]);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_reset_mid_mdu();
    logic [9:0] got;
    idle();
    hz.mdu_start = 1'b1;
    next_cycle();
    idle();
    for (int i = 0; i < 5; i++) next_cycle();
    got = obs(); n_cmp++;
    if (got !== {S_MDU, O_BUSY}) begin
      n_fail++; $display("FAIL pre_reset_mdu: got %b want %b", got, {S_MDU, O_BUSY});
    end
    rst_n = 1'b0;
    #1;
    got = obs(); n_cmp++;
    if (got !== {S_RUN, O_NONE}) begin
      n_fail++; $display("FAIL async_reset: got %b want %b", got, {S_RUN, O_NONE});
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    got = obs(); n_cmp++;
    if (got !== {S_RUN, O_NONE}) begin
      n_fail++; $display("FAIL post_reset_first: got %b want %b", got, {S_RUN, O_NONE});
    end
    next_cycle();
    test_mdu_timeout(1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_load_use();
    test_branch_flush();
    test_mdu_done();
    test_mdu_timeout(1'b0);
    test_mdu_timeout(1'b1);
    test_mem_then_mdu();
    test_back_to_back_mem();
    test_reset_mid_mdu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
